// File: rtl/kernel3x3_pkg.sv
// kernel3x3_pkg: types shared by the 3x3 filter.
//   mode_t  - kernel select encodings (00 sobel, 01 gaussian, 10 passthrough,
//             11 reserved and handled as passthrough)
//   state_t - frame sequencing states
//   row_rot - modulo-3 step for the rolling line-buffer row pointers
package kernel3x3_pkg;

  typedef enum logic [1:0] {
    MODE_SOBEL = 2'b00,
    MODE_GAUSS = 2'b01,
    MODE_PASS  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // (row + step) mod 3, for row and step in 0..2
  function automatic logic [1:0] row_rot(input logic [1:0] row, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, row} + {1'b0, step};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/kernel3x3_filter_if.sv
// kernel3x3_filter_if: FIFO-side handshake of the 3x3 filter.
//   in_rd_en/in_empty/in_dout    - first-word-fall-through input FIFO
//   out_wr_en/out_full/out_din   - output FIFO
//   modport master: filter side, modport slave: FIFO side.
interface kernel3x3_filter_if #(
  parameter int PIX_W = 8
);
  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );
endinterface

// File: rtl/kernel3x3_datapath.sv
// kernel3x3_datapath: combinational 3x3 window arithmetic.
//   mode   - kernel select (frame-sampled copy)
//   border - centre pixel lies on the image border
//   win    - 3x3 window, row-major, win[4] is the centre
//   pix    - filtered pixel
module kernel3x3_datapath
  import kernel3x3_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  mode_t            mode,
  input  logic             border,
  input  logic [PIX_W-1:0] win [9],
  output logic [PIX_W-1:0] pix
);
  localparam int SW = PIX_W + 4;  // signed gradient width
  localparam int UW = PIX_W + 5;  // unsigned sum width, holds 16*max+8
  localparam logic [UW-1:0] PIX_MAX = UW'((1 << PIX_W) - 1);

  function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
    return v[SW-1] ? SW'(-v) : SW'(v);
  endfunction

  logic signed [SW-1:0] s [9];
  logic [UW-1:0]        u [9];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_ext
      assign s[gi] = $signed({4'b0000, win[gi]});
      assign u[gi] = UW'(win[gi]);
    end
  endgenerate

  logic signed [SW-1:0] gx, gy;
  logic [UW-1:0]        mag, sobel_half, gauss_sum;
  logic [PIX_W-1:0]     sobel_pix, gauss_pix;

  assign gx = (s[2] + (s[5] <<< 1) + s[8]) - (s[0] + (s[3] <<< 1) + s[6]);
  assign gy = (s[6] + (s[7] <<< 1) + s[8]) - (s[0] + (s[1] <<< 1) + s[2]);
  assign mag = UW'(abs_val(gx)) + UW'(abs_val(gy));
  assign sobel_half = mag >> 1;
  assign sobel_pix = (sobel_half > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : sobel_half[PIX_W-1:0];

  // Rounded divide by 16; the weights sum to 16 so the result never exceeds full scale.
  assign gauss_sum = u[0] + (u[1] << 1) + u[2]
                   + (u[3] << 1) + (u[4] << 2) + (u[5] << 1)
                   + u[6] + (u[7] << 1) + u[8] + UW'(8);
  assign gauss_pix = PIX_W'(gauss_sum >> 4);

  always_comb begin
    pix = '0;
    case (mode)
      MODE_SOBEL: if (!border) pix = sobel_pix;
      MODE_GAUSS: if (!border) pix = gauss_pix;
      default:    pix = win[4];
    endcase
  end
endmodule

// File: rtl/kernel3x3_filter.sv
// kernel3x3_filter: streaming 3x3 filter (sobel / gaussian / passthrough)
// between two FIFOs, WIDTH x HEIGHT frames in raster order.
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   mode           - kernel select, sampled at frame start
//   fifo           - input/output FIFO handshake (master side)
//   busy           - frame in progress
//   frame_done     - one-cycle pulse after the last write of a frame
module kernel3x3_filter
  import kernel3x3_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int PIX_W  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  kernel3x3_filter_if.master fifo,
  output logic               busy,
  output logic               frame_done
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int EW   = CW + 2;
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam logic [CW-1:0] NPIX_C  = CW'(NPIX);
  localparam logic [CW-1:0] LAST_C  = CW'(NPIX - 1);
  localparam logic [EW-1:0] WR_LEAD = EW'(WIDTH + 1);
  localparam logic [EW-1:0] RD_LEAD = EW'(2 * WIDTH - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);

  state_t        state_reg;
  mode_t         mode_reg;
  logic [CW-1:0] in_count_reg, out_count_reg;
  logic [XW-1:0] in_x_reg, out_x_reg;
  logic [YW-1:0] out_y_reg;
  logic [1:0]    in_row_reg, out_row_reg;
  logic          busy_reg, frame_done_reg;

  logic [EW-1:0] in_ext, out_ext;
  logic          rd_en, wr_en, last_wr;

  assign in_ext  = EW'(in_count_reg);
  assign out_ext = EW'(out_count_reg);

  // Only three rows are stored, so the reader may not run more than
  // 2*WIDTH-1 pixels ahead of the writer: beyond that a new pixel would
  // overwrite the oldest row still needed by the pending output window.
  // This bound is always above the WIDTH+2 lead the writer waits for.
  assign rd_en = (state_reg == ST_RUN) && !fifo.in_empty &&
                 (in_count_reg < NPIX_C) && (in_ext < out_ext + RD_LEAD);
  assign wr_en = !fifo.out_full && (out_count_reg < NPIX_C) &&
                 ((in_ext > out_ext + WR_LEAD) || (in_count_reg == NPIX_C));
  assign last_wr = wr_en && (out_count_reg == LAST_C);

  // Window columns clamp at the image edge; those positions are border
  // pixels so the clamped taps only matter in passthrough (centre only).
  logic [XW-1:0] col_l, col_r;
  assign col_l = (out_x_reg == '0) ? out_x_reg : out_x_reg - XW'(1);
  assign col_r = (out_x_reg == X_LAST) ? out_x_reg : out_x_reg + XW'(1);

  logic [PIX_W-1:0] row_tap [3][3];

  // Buffer k holds image rows y with y mod 3 == k.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_line
      logic [PIX_W-1:0] line_mem [WIDTH];
      always_ff @(posedge clock) begin
        if (rd_en && (in_row_reg == 2'(gi))) line_mem[in_x_reg] <= fifo.in_dout;
      end
      assign row_tap[gi][0] = line_mem[col_l];
      assign row_tap[gi][1] = line_mem[out_x_reg];
      assign row_tap[gi][2] = line_mem[col_r];
    end
  endgenerate

  logic [1:0]       row_top, row_bot;
  logic [PIX_W-1:0] win [9];
  logic [PIX_W-1:0] dp_pix;
  logic             border;

  assign row_top = row_rot(out_row_reg, 2'd2);
  assign row_bot = row_rot(out_row_reg, 2'd1);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      assign win[gi]     = row_tap[row_top][gi];
      assign win[3 + gi] = row_tap[out_row_reg][gi];
      assign win[6 + gi] = row_tap[row_bot][gi];
    end
  endgenerate

  assign border = (out_y_reg == '0) || (out_y_reg == Y_LAST) ||
                  (out_x_reg == '0) || (out_x_reg == X_LAST);

  kernel3x3_datapath #(.PIX_W(PIX_W)) u_datapath (
    .mode   (mode_reg),
    .border (border),
    .win    (win),
    .pix    (dp_pix)
  );

  assign fifo.in_rd_en  = rd_en;
  assign fifo.out_wr_en = wr_en;
  assign fifo.out_din   = wr_en ? dp_pix : '0;
  assign busy           = busy_reg;
  assign frame_done     = frame_done_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_SOBEL;
      in_count_reg   <= '0;
      out_count_reg  <= '0;
      in_x_reg       <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      in_row_reg     <= '0;
      out_row_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      if (rd_en) begin
        in_count_reg <= in_count_reg + CW'(1);
        if (in_x_reg == X_LAST) begin
          in_x_reg   <= '0;
          in_row_reg <= row_rot(in_row_reg, 2'd1);
        end else begin
          in_x_reg <= in_x_reg + XW'(1);
        end
      end

      if (wr_en) begin
        out_count_reg <= out_count_reg + CW'(1);
        if (out_x_reg == X_LAST) begin
          out_x_reg   <= '0;
          out_y_reg   <= out_y_reg + YW'(1);
          out_row_reg <= row_rot(out_row_reg, 2'd1);
        end else begin
          out_x_reg <= out_x_reg + XW'(1);
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (!fifo.in_empty) begin
            state_reg <= ST_RUN;
            mode_reg  <= mode_t'(mode);
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN:   if (rd_en && (in_count_reg == LAST_C)) state_reg <= ST_DRAIN;
        ST_DRAIN: ;
        default:  state_reg <= ST_IDLE;
      endcase

      // Final write: everything rewinds so the next frame can start at once.
      if (last_wr) begin
        state_reg      <= ST_IDLE;
        in_count_reg   <= '0;
        out_count_reg  <= '0;
        in_x_reg       <= '0;
        out_x_reg      <= '0;
        out_y_reg      <= '0;
        in_row_reg     <= '0;
        out_row_reg    <= '0;
        busy_reg       <= 1'b0;
        frame_done_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kernel3x3_filter.sv
// tb_kernel3x3_filter: self-checking bench for kernel3x3_filter, 8x6 frames.
module tb_kernel3x3_filter;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       busy, frame_done;

  always #5 clock = ~clock;

  kernel3x3_filter_if #(.PIX_W(8)) fifo_if ();

  kernel3x3_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mode       (mode),
    .fifo       (fifo_if),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef logic [7:0] img_t [N];
  typedef struct { int scen; int x; int y; logic [7:0] exp; } vec_t;
  typedef struct { logic [1:0] mode; int pat; } scen_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_all[$];
  int rd_total, done_total, cyc, viol, full_pct;
  bit burst_en, burst_on;
  int done_cyc[$], done_rd[$], start_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: direct 2-D evaluation of the kernel definitions.
  function automatic int wgt(input int d);
    return 2 - ((d < 0) ? -d : d);
  endfunction

  function automatic int px(input img_t img, input int x, input int y);
    return int'(img[y * W + x]);
  endfunction

  function automatic logic [7:0] ref_pix(input img_t img, input logic [1:0] m, input int x, input int y);
    int gx, gy, g, r;
    gx = 0; gy = 0; g = 0;
    if (m[1]) return img[y * W + x];
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 8'd0;
    for (int d = -1; d <= 1; d++) begin
      gx += wgt(d) * (px(img, x + 1, y + d) - px(img, x - 1, y + d));
      gy += wgt(d) * (px(img, x + d, y + 1) - px(img, x + d, y - 1));
      for (int e = -1; e <= 1; e++) g += wgt(d) * wgt(e) * px(img, x + e, y + d);
    end
    if (m == 2'b00) begin
      r = (((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy)) / 2;
      return (r > 255) ? 8'd255 : 8'(r);
    end
    return 8'((g + 8) / 16);
  endfunction

  task automatic make_img(input int pat, output img_t img);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       img[i] = 8'(i);
        1:       img[i] = ((i % W) < 4) ? 8'd0 : 8'd255;
        2:       img[i] = 8'd100;
        4:       img[i] = 8'(i + 100);
        default: img[i] = 8'($urandom_range(255));
      endcase
    end
  endtask

  task automatic push_img(input img_t img);
    for (int i = 0; i < N; i++) in_q.push_back(img[i]);
  endtask

  task automatic clear_book();
    in_q.delete(); out_all.delete();
    rd_total = 0; done_total = 0; viol = 0;
    done_cyc.delete(); done_rd.delete(); start_cyc.delete();
  endtask

  // One clock: drive FIFO inputs at the falling edge, sample DUT 1 ns later.
  task automatic step();
    @(negedge clock);
    if (burst_en && $urandom_range(99) < 20) burst_on = ~burst_on;
    fifo_if.in_empty = (in_q.size() == 0) || (burst_en && burst_on);
    fifo_if.in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
    fifo_if.out_full = ($urandom_range(99) < 32'(full_pct));
    #1;
    cyc++;
    if (fifo_if.in_rd_en) begin
      if (fifo_if.in_empty) viol++;
      else begin
        if (rd_total % N == 0) start_cyc.push_back(cyc);
        void'(in_q.pop_front());
        rd_total++;
      end
    end
    if (fifo_if.out_wr_en) begin
      if (fifo_if.out_full) viol++;
      out_all.push_back(fifo_if.out_din);
    end else if (fifo_if.out_din !== 8'h00) viol++;
    if (frame_done) begin
      done_total++;
      done_cyc.push_back(cyc);
      done_rd.push_back(rd_total);
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (done_total < target && n < 3000) begin step(); n++; end
    repeat (4) step();
    check({name, "_frame_done_pulses"}, done_total, target);
  endtask

  task automatic cmp_frame(input string name, input int k, input img_t img, input logic [1:0] m);
    int bad, first;
    bad = 0; first = 0;
    checks++;
    if (out_all.size() < N * (k + 1)) begin
      failures++;
      $display("FAIL %s output_count actual=%0d required=%0d", name, out_all.size(), N * (k + 1));
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (out_all[N * k + i] !== ref_pix(img, m, i % W, i / W)) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    if (bad != 0) begin
      failures++;
      $display("FAIL %s pixel=%0d actual=%0d required=%0d differing=%0d", name, first,
               out_all[N * k + first], ref_pix(img, m, first % W, first / W), bad);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_in_rd_en"}, fifo_if.in_rd_en, 0);
    check({tag, "_out_wr_en"}, fifo_if.out_wr_en, 0);
    check({tag, "_out_din"}, fifo_if.out_din, 0);
  endtask

  initial begin
    scen_t sc [3];
    vec_t  vt [14];
    img_t  img, img2;
    int    n, idx;

    sc = '{'{2'b10, 0}, '{2'b00, 1}, '{2'b01, 2}};
    vt = '{'{0, 0, 0, 8'd0},   '{0, 3, 2, 8'd19},  '{0, 7, 5, 8'd47},
           '{1, 3, 2, 8'd255}, '{1, 4, 3, 8'd255}, '{1, 2, 2, 8'd0},
           '{1, 5, 4, 8'd0},   '{1, 3, 0, 8'd0},   '{1, 4, 5, 8'd0},
           '{1, 0, 3, 8'd0},   '{2, 1, 1, 8'd100}, '{2, 6, 4, 8'd100},
           '{2, 0, 0, 8'd0},   '{2, 7, 2, 8'd0}};

    cyc = 0; full_pct = 0; burst_en = 0; burst_on = 0; mode = 2'b00;
    fifo_if.in_empty = 1'b0; fifo_if.in_dout = 8'h00; fifo_if.out_full = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock); #1;
    check_reset_outputs("reset");
    @(negedge clock);
    fifo_if.in_empty = 1'b1;
    reset_n = 1'b1;
    clear_book();

    // Directed frames with table spot checks
    for (int s = 0; s < 3; s++) begin
      clear_book();
      mode = sc[s].mode;
      make_img(sc[s].pat, img);
      push_img(img);
      wait_frames(1, $sformatf("dir%0d", s));
      cmp_frame($sformatf("dir%0d_frame", s), 0, img, sc[s].mode);
      check($sformatf("dir%0d_protocol", s), viol, 0);
      if (done_rd.size() > 0) check($sformatf("dir%0d_reads_at_done", s), done_rd[0], N);
      for (int v = 0; v < 14; v++) begin
        if (vt[v].scen == s) begin
          idx = vt[v].y * W + vt[v].x;
          check($sformatf("vec_s%0d_x%0d_y%0d", s, vt[v].x, vt[v].y),
                (out_all.size() > idx) ? 32'(out_all[idx]) : 32'hFFFF_FFFF, 32'(vt[v].exp));
        end
      end
    end

    // Random images with output stalls and input bursts
    for (int r = 0; r < 3; r++) begin
      clear_book();
      burst_en = 1; full_pct = 50;
      mode = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      make_img(3, img);
      push_img(img);
      wait_frames(1, $sformatf("rand%0d", r));
      cmp_frame($sformatf("rand%0d_frame", r), 0, img, mode);
      check($sformatf("rand%0d_protocol", r), viol, 0);
      if (done_rd.size() > 0) check($sformatf("rand%0d_reads_at_done", r), done_rd[0], N);
    end
    burst_en = 0; burst_on = 0; full_pct = 0;

    // Reset in the middle of a frame, then a fresh passthrough frame
    clear_book();
    mode = 2'b10;
    make_img(3, img);
    push_img(img);
    n = 0;
    while (rd_total < 20 && n < 500) begin step(); n++; end
    check("midrst_reached_pixel20", rd_total, 20);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_book();
    fifo_if.in_empty = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    make_img(4, img2);
    push_img(img2);
    wait_frames(1, "rst");
    cmp_frame("rst_new_frame", 0, img2, 2'b10);
    check("rst_output_count", out_all.size(), N);
    check("rst_protocol", viol, 0);

    // Mode change mid-frame, second frame queued back to back
    clear_book();
    mode = 2'b00; full_pct = 30;
    make_img(3, img);
    make_img(3, img2);
    push_img(img);
    push_img(img2);
    n = 0;
    while (rd_total < 10 && n < 500) begin step(); n++; end
    mode = 2'b01;
    wait_frames(2, "mode");
    cmp_frame("mode_frameA_sobel", 0, img, 2'b00);
    cmp_frame("mode_frameB_gauss", 1, img2, 2'b01);
    check("mode_protocol", viol, 0);
    check("b2b_frame_starts", start_cyc.size(), 2);
    if (start_cyc.size() >= 2 && done_cyc.size() >= 1)
      check("b2b_gap_cycles", start_cyc[1] - done_cyc[0], 1);
    if (done_rd.size() >= 2) begin
      check("mode_reads_at_doneA", done_rd[0], N);
      check("mode_reads_at_doneB", done_rd[1], 2 * N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
